// File: rtl/key_digit_entry.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_digit_entry                                                            |
// | Single-key digit entry: a short press bumps the digit, a long press        |
// | commits it into an 8-nibble word for the display.                          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module key_digit_entry #(
    parameter int DB_CYCLES   = 1_000_000,
    parameter int LONG_CYCLES = 50_000_000,
    parameter int DIGIT_MAX   = 9
) (
    input  logic        CLOCK_50,
    input  logic        rst,
    input  logic        key_in,
    input  logic        clr,
    output logic [3:0]  cur_digit,
    output logic [31:0] word_out,
    output logic [31:0] disp_data,
    output logic        key_flag,
    output logic        commit
);

    localparam int DB_W   = (DB_CYCLES > 1)   ? $clog2(DB_CYCLES)   : 1;
    localparam int HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [3:0]        DIGIT_TOP = 4'(DIGIT_MAX);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESSED = 2'd1;
    localparam logic [1:0] S_HELD    = 2'd2;

    logic [1:0]        sync_q;
    logic [DB_W-1:0]   db_cnt_q,    db_cnt_d;
    logic              key_state_q, key_state_d;
    logic [1:0]        state_q,     state_d;
    logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic [3:0]        cur_q,       cur_d;
    logic [31:0]       word_q,      word_d;
    logic              flag_q,      flag_d;
    logic              commit_q,    commit_d;
    logic              short_act;
    logic              long_act;

    // Debounce: the stable level is adopted only after DB_CYCLES consecutive disagreements.
    always_comb begin
        db_cnt_d    = '0;
        key_state_d = key_state_q;
        if (sync_q[1] != key_state_q) begin
            if (db_cnt_q == DB_LAST) begin
                key_state_d = sync_q[1];
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (!key_state_q) state_d = S_PRESSED;
            S_PRESSED: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = S_HELD;
                end else if (key_state_q) begin
                    state_d = S_IDLE;
                end
            end
            S_HELD:    if (key_state_q) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // The long action wins if the release is seen on the very cycle the hold expires.
    always_comb begin
        flag_d     = (state_q == S_IDLE) && !key_state_q;
        long_act   = (state_q == S_PRESSED) && (hold_cnt_q == HOLD_LAST);
        short_act  = (state_q == S_PRESSED) && !long_act && key_state_q;
        commit_d   = long_act;
        hold_cnt_d = hold_cnt_q;
        if (flag_d) begin
            hold_cnt_d = '0;
        end else if ((state_q == S_PRESSED) && (hold_cnt_q != HOLD_LAST)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    always_comb begin
        cur_d  = cur_q;
        word_d = word_q;
        if (long_act) begin
            word_d = {word_q[27:0], cur_q};
            cur_d  = 4'd0;
        end else if (short_act) begin
            cur_d = (cur_q == DIGIT_TOP) ? 4'd0 : cur_q + 4'd1;
        end
        if (clr) begin
            cur_d  = 4'd0;
            word_d = 32'd0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            sync_q      <= 2'b11;
            db_cnt_q    <= '0;
            key_state_q <= 1'b1;
            state_q     <= S_IDLE;
            hold_cnt_q  <= '0;
            cur_q       <= 4'd0;
            word_q      <= 32'd0;
            flag_q      <= 1'b0;
            commit_q    <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], key_in};
            db_cnt_q    <= db_cnt_d;
            key_state_q <= key_state_d;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            cur_q       <= cur_d;
            word_q      <= word_d;
            flag_q      <= flag_d;
            commit_q    <= commit_d;
        end
    end

    assign cur_digit = cur_q;
    assign word_out  = word_q;
    assign disp_data = {word_q[27:0], cur_q};
    assign key_flag  = flag_q;
    assign commit    = commit_q;

endmodule
`default_nettype wire

// File: tb/tb_key_digit_entry.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_key_digit_entry                                                         |
// | Scoreboard bench: presses queue expected pulses, a monitor checks them.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_key_digit_entry;

    typedef struct {
        bit          is_commit;
        int          cyc;
        logic [3:0]  cur;
        logic [31:0] word;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_in = 1'b1;
    logic        clr = 1'b0;
    logic [3:0]  cur_digit;
    logic [31:0] word_out;
    logic [31:0] disp_data;
    logic        key_flag;
    logic        commit;

    int          cyc = 0;
    int          vectors = 0;
    int          errors = 0;
    ev_t         sb[$];
    ev_t         mon_e;
    logic [3:0]  m_cur = 4'd0;
    logic [31:0] m_word = 32'd0;

    key_digit_entry #(
        .DB_CYCLES   (4),
        .LONG_CYCLES (20),
        .DIGIT_MAX   (9)
    ) dut (
        .CLOCK_50  (clk),
        .rst       (rst),
        .key_in    (key_in),
        .clr       (clr),
        .cur_digit (cur_digit),
        .word_out  (word_out),
        .disp_data (disp_data),
        .key_flag  (key_flag),
        .commit    (commit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_cur"},  {28'd0, cur_digit}, {28'd0, m_cur});
        chk({tag, "_word"}, word_out, m_word);
        chk({tag, "_disp"}, disp_data, {m_word[27:0], m_cur});
    endtask

    // Key goes low just after edge c: flag at c+7, commit (if held long) at c+27.
    task automatic press(input int hold);
        int  c;
        ev_t e;
        @(negedge clk);
        key_in = 1'b0;
        c = cyc;
        e.is_commit = 1'b0; e.cyc = c + 7; e.cur = m_cur; e.word = m_word;
        sb.push_back(e);
        if (hold >= 30) begin
            m_word = {m_word[27:0], m_cur};
            m_cur  = 4'd0;
            e.is_commit = 1'b1; e.cyc = c + 27; e.cur = m_cur; e.word = m_word;
            sb.push_back(e);
        end else begin
            m_cur = (m_cur == 4'd9) ? 4'd0 : m_cur + 4'd1;
        end
        repeat (hold) @(negedge clk);
        key_in = 1'b1;
        repeat (12) @(negedge clk);
        chk_state("press");
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_cur  = 4'd0;
        m_word = 32'd0;
        chk_state("clr");
    endtask

    always @(negedge clk) begin
        if (!rst && (key_flag || commit)) begin
            if (key_flag && commit) begin
                vectors++;
                errors++;
                $display("FAIL pulse_overlap: got flag=1 commit=1, required at most one (cycle %0d)", cyc);
            end
            if (sb.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_pulse: got flag=%0b commit=%0b, required none (cycle %0d)",
                         key_flag, commit, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("pulse_kind",  {31'd0, commit}, {31'd0, mon_e.is_commit});
                chk("pulse_cycle", cyc, mon_e.cyc);
                chk("pulse_cur",   {28'd0, cur_digit}, {28'd0, mon_e.cur});
                chk("pulse_word",  word_out, mon_e.word);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
        $fatal(1);
    end

    initial begin
        int  r;
        ev_t e;

        // Reset and idle
        repeat (3) @(negedge clk);
        chk_state("reset");
        chk("reset_flag", {31'd0, key_flag}, 32'd0);
        chk("reset_commit", {31'd0, commit}, 32'd0);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk_state("idle");

        // Bounces shorter than the debounce window
        for (int i = 0; i < 5; i++) begin
            key_in = 1'b0;
            repeat (3) @(negedge clk);
            key_in = 1'b1;
            repeat (3) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk_state("bounce");

        // Eleven short presses: 1..9, 0, 1
        for (int i = 0; i < 11; i++) press(10);
        chk("short_end_cur", {28'd0, cur_digit}, 32'd1);

        // Long press after three shorts
        pulse_clr();
        for (int i = 0; i < 3; i++) press(10);
        chk("pre_long_cur", {28'd0, cur_digit}, 32'd3);
        press(40);
        chk("long_word", word_out, 32'h0000_0003);

        // Nine commits of digits 1..9, then clear
        for (int d = 1; d <= 9; d++) begin
            for (int k = 0; k < d; k++) press(10);
            press(40);
        end
        chk("wrap_word", word_out, 32'h2345_6789);
        chk("wrap_disp", disp_data, 32'h3456_7890);
        press(10);
        pulse_clr();

        // Reset ten cycles into a long press, key still held
        press(10);
        @(negedge clk);
        key_in = 1'b0;
        e.is_commit = 1'b0; e.cyc = cyc + 7; e.cur = m_cur; e.word = m_word;
        sb.push_back(e);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        m_cur  = 4'd0;
        m_word = 32'd0;
        repeat (3) @(negedge clk);
        chk_state("midrst");
        chk("midrst_flag", {31'd0, key_flag}, 32'd0);
        chk("midrst_commit", {31'd0, commit}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        r = cyc;
        e.is_commit = 1'b0; e.cyc = r + 7;  e.cur = 4'd0; e.word = 32'd0;
        sb.push_back(e);
        e.is_commit = 1'b1; e.cyc = r + 27; e.cur = 4'd0; e.word = 32'd0;
        sb.push_back(e);
        repeat (40) @(negedge clk);
        key_in = 1'b1;
        repeat (12) @(negedge clk);
        chk_state("repress");

        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
